note_key_encoder: RTL and testbench
===================================

NOTE_KEY_ENCODER -- requirements
Module: note_key_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable cycles required to accept a key change (5 ms at 50 MHz); legal range 1..2^20.
REQ-002 SHALL have port Clock  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Enable  input  1  logic 1 enables note detection.
REQ-005 SHALL have port KeyArray  input  3  raw asynchronous push-buttons, one-hot per note: bit0=C, bit1=D, bit2=E.
REQ-006 SHALL have port NoteNumber  output  4  last accepted note code: C=1, D=2, E=3; 0 = none.
REQ-007 SHALL have port NoteValid  output  1  one-cycle pulse marking a new NoteNumber.
REQ-008 SHALL have port NoteHeld  output  1  high while the accepted key remains debounced-pressed.

Function
REQ-009 SHALL pass each KeyArray bit through a 2-flop synchronizer before any other use.
REQ-010 SHALL debounce each synchronized bit independently:
- per-key counter clears when sync equals debounced;
- increments while they differ;
- on the DEBOUNCE_CYCLES-th consecutive differing cycle, debounced takes the sync value and the counter clears.
REQ-011 SHALL size each counter as ceil(log2(DEBOUNCE_CYCLES+1)) bits; the counter never wraps.
REQ-012 SHALL implement FSM states IDLE, PRESSED and WAIT_RELEASE.
REQ-013 IDLE -> PRESSED when Enable=1 and the debounced vector is exactly one-hot. In the same transition: NoteNumber is loaded (001->1, 010->2, 100->3), NoteValid pulses for one cycle, and NoteHeld is set.
REQ-014 IDLE -> WAIT_RELEASE when Enable=1 and the debounced vector has 2 or more bits set; no pulse is emitted and NoteNumber is unchanged.
REQ-015 PRESSED -> IDLE when the debounced vector becomes 000; NoteHeld clears in the same transition.
REQ-016 PRESSED -> WAIT_RELEASE when the debounced vector is nonzero and differs from the accepted key (key added or switched); NoteHeld clears and no new pulse is emitted.
REQ-017 WAIT_RELEASE -> IDLE only when the debounced vector is 000 and Enable=1.
REQ-018 While Enable=0:
- state is forced to WAIT_RELEASE;
- NoteValid=0 and NoteHeld=0;
- NoteNumber retains its value;
- debouncers keep running.
REQ-019 NoteValid SHALL assert exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a stable raw press (2 sync + DEBOUNCE_CYCLES debounce + 1 FSM register).
REQ-020 SHALL emit at most one NoteValid pulse per press; a key held indefinitely produces no further pulses.
REQ-021 NoteValid and NoteHeld SHALL be registered outputs, free of combinational paths from inputs.
REQ-022 Raw glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.

Reset
REQ-023 Reset SHALL take priority over Enable and all other inputs.
REQ-024 On Reset SHALL clear: synchronizers, debounced vector and counters to 0, FSM to IDLE, NoteNumber=0, NoteValid=0, NoteHeld=0.
REQ-025 Reset asserted mid-press SHALL abort the press with no pulse. After release, a key still held needs a full debounce period before it is accepted.

Structure
REQ-026 The note codes (NOTE_NONE=0, NOTE_C=1, NOTE_D=2, NOTE_E=3), the one-hot key constants and the FSM state encoding SHALL live in the shared note package used by the note-to-key mapper.
REQ-027 SHALL instantiate one sub-module, key_debouncer (synchronizer plus counter, parameter DEBOUNCE_CYCLES), three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, Enable=1, KeyArray=010 held -> one NoteValid pulse 7 edges later, NoteNumber=2, NoteHeld=1 until 7 edges after release.
REQ-029 KeyArray=001 glitch lasting 3 cycles -> NoteValid never asserts, NoteNumber stays 0.
REQ-030 Press 100, then add 001 while held -> first NoteNumber=3 pulse; NoteHeld drops after the 101 debounce; no second pulse until a full release and a fresh press.
REQ-031 KeyArray=011 applied simultaneously from idle -> no pulse; release, then 001 -> pulse with NoteNumber=1.
REQ-032 Enable=0 during a held press of 010 -> NoteHeld=0; re-enable while held -> no pulse; release, then 010 -> pulse.
REQ-033 Reset asserted 2 cycles before the expected pulse -> no pulse, all outputs 0; key held after reset -> pulse 7 edges after Reset deasserts.

Source files
------------

// File: rtl/note_key_encoder_pkg.sv
// Shared note definitions: note codes, one-hot key constants and encoder FSM states.
package note_key_encoder_pkg;

  localparam int NUM_KEYS = 3;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;

  localparam logic [NUM_KEYS-1:0] KEY_NONE = 3'b000;
  localparam logic [NUM_KEYS-1:0] KEY_C    = 3'b001;
  localparam logic [NUM_KEYS-1:0] KEY_D    = 3'b010;
  localparam logic [NUM_KEYS-1:0] KEY_E    = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESSED      = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } note_state_t;

  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
    return (v != KEY_NONE) && ((v & (v - 1'b1)) == KEY_NONE);
  endfunction

  function automatic logic [3:0] key_to_note(input logic [NUM_KEYS-1:0] v);
    case (v)
      KEY_C:   return NOTE_C;
      KEY_D:   return NOTE_D;
      KEY_E:   return NOTE_E;
      default: return NOTE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/note_key_encoder_debouncer.sv
// key_debouncer: 2-flop synchronizer followed by a saturating-free stability counter.
// The debounced level follows the synchronized level after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q, sync_q;
  logic          deb_q,  deb_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  // Counter only reaches DEBOUNCE_CYCLES-1 before clearing, so it cannot wrap.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/note_key_encoder.sv
// Debounces three one-hot note keys and reports the accepted note with a one-cycle valid pulse
// and a held level; chords, switches and disable periods must fully release before a new note.
module note_key_encoder
  import note_key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [NUM_KEYS-1:0] KeyArray,
  output logic [3:0]          NoteNumber,
  output logic                NoteValid,
  output logic                NoteHeld
);

  logic [NUM_KEYS-1:0] deb_keys;
  logic [NUM_KEYS-1:0] key_q;
  logic [3:0]          note_q;
  logic                valid_q, held_q;
  note_state_t         state_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (Clock),
      .rst_i (Reset),
      .raw_i (KeyArray[k]),
      .deb_o (deb_keys[k])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      key_q   <= KEY_NONE;
      note_q  <= NOTE_NONE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else if (!Enable) begin
      // Parking in WAIT_RELEASE forces a clean release before the next note.
      state_q <= ST_WAIT_RELEASE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (is_one_hot(deb_keys)) begin
            state_q <= ST_PRESSED;
            key_q   <= deb_keys;
            note_q  <= key_to_note(deb_keys);
            valid_q <= 1'b1;
            held_q  <= 1'b1;
          end else if (deb_keys != KEY_NONE) begin
            state_q <= ST_WAIT_RELEASE;
          end
        end
        ST_PRESSED: begin
          if (deb_keys == KEY_NONE) begin
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
          end else if (deb_keys != key_q) begin
            state_q <= ST_WAIT_RELEASE;
            held_q  <= 1'b0;
          end
        end
        ST_WAIT_RELEASE: begin
          if (deb_keys == KEY_NONE) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign NoteNumber = note_q;
  assign NoteValid  = valid_q;
  assign NoteHeld   = held_q;

endmodule

// File: tb/tb_note_key_encoder.sv
// Directed bench for note_key_encoder with DEBOUNCE_CYCLES=4 (press-to-pulse latency of 7 edges).
module tb_note_key_encoder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [2:0] KeyArray;
  logic [3:0] NoteNumber;
  logic       NoteValid;
  logic       NoteHeld;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int snap;

  note_key_encoder #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .KeyArray   (KeyArray),
    .NoteNumber (NoteNumber),
    .NoteValid  (NoteValid),
    .NoteHeld   (NoteHeld)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (NoteValid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; KeyArray = 3'b000;
    cyc(3);
    check("rst_note", NoteNumber, 0);
    check("rst_valid", NoteValid, 0);
    check("rst_held", NoteHeld, 0);
    Reset = 1'b0;
    Enable = 1'b1;

    // Single press of D: pulse exactly 7 edges after the first sampling edge.
    KeyArray = 3'b010;
    cyc(6);
    check("d_early_valid", NoteValid, 0);
    cyc(1);
    check("d_valid", NoteValid, 1);
    check("d_note", NoteNumber, 2);
    check("d_held", NoteHeld, 1);
    cyc(1);
    check("d_valid_1cyc", NoteValid, 0);
    cyc(20);
    check("d_one_pulse", pulses, 1);
    check("d_still_held", NoteHeld, 1);
    KeyArray = 3'b000;
    cyc(6);
    check("d_rel_held6", NoteHeld, 1);
    cyc(1);
    check("d_rel_held7", NoteHeld, 0);
    check("d_rel_note", NoteNumber, 2);
    cyc(3);

    // Short glitch on C from a clean reset.
    do_reset();
    snap = pulses;
    KeyArray = 3'b001;
    cyc(3);
    KeyArray = 3'b000;
    cyc(15);
    check("glitch_pulses", pulses - snap, 0);
    check("glitch_note", NoteNumber, 0);
    check("glitch_held", NoteHeld, 0);

    // Press E, then add C while held.
    snap = pulses;
    KeyArray = 3'b100;
    cyc(7);
    check("e_valid", NoteValid, 1);
    check("e_note", NoteNumber, 3);
    cyc(2);
    KeyArray = 3'b101;
    cyc(6);
    check("add_held6", NoteHeld, 1);
    cyc(1);
    check("add_held7", NoteHeld, 0);
    cyc(20);
    check("add_pulses", pulses - snap, 1);
    check("add_note", NoteNumber, 3);
    KeyArray = 3'b000;
    cyc(10);
    check("add_rel_pulses", pulses - snap, 1);
    KeyArray = 3'b100;
    cyc(7);
    check("e_fresh_valid", NoteValid, 1);
    KeyArray = 3'b000;
    cyc(10);
    check("e_fresh_pulses", pulses - snap, 2);

    // Simultaneous chord from idle.
    snap = pulses;
    KeyArray = 3'b011;
    cyc(20);
    check("chord_pulses", pulses - snap, 0);
    check("chord_held", NoteHeld, 0);
    check("chord_note", NoteNumber, 3);
    KeyArray = 3'b000;
    cyc(10);
    KeyArray = 3'b001;
    cyc(7);
    check("c_valid", NoteValid, 1);
    check("c_note", NoteNumber, 1);
    KeyArray = 3'b000;
    cyc(10);

    // Disable during a held press.
    KeyArray = 3'b010;
    cyc(7);
    check("en_valid", NoteValid, 1);
    cyc(2);
    snap = pulses;
    Enable = 1'b0;
    cyc(1);
    check("dis_held", NoteHeld, 0);
    check("dis_valid", NoteValid, 0);
    cyc(5);
    check("dis_note", NoteNumber, 2);
    Enable = 1'b1;
    cyc(10);
    check("reen_pulses", pulses - snap, 0);
    check("reen_held", NoteHeld, 0);
    KeyArray = 3'b000;
    cyc(10);
    KeyArray = 3'b010;
    cyc(7);
    check("reen_valid", NoteValid, 1);
    KeyArray = 3'b000;
    cyc(10);

    // Reset two cycles before the expected pulse, key kept pressed.
    snap = pulses;
    KeyArray = 3'b100;
    cyc(4);
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    check("rmid_note", NoteNumber, 0);
    check("rmid_valid", NoteValid, 0);
    check("rmid_held", NoteHeld, 0);
    check("rmid_pulses", pulses - snap, 0);
    cyc(6);
    check("rmid_early", NoteValid, 0);
    cyc(1);
    check("rmid_valid7", NoteValid, 1);
    check("rmid_note7", NoteNumber, 3);
    cyc(5);
    check("rmid_total", pulses - snap, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
